wb_line_buffer: RTL and testbench
=================================

Name: wb_line_buffer

Overview:
- Write-back line buffer between the data cache memory port and the off-chip data memory model.
- Accepts dirty-line write-backs from the cache and acknowledges them quickly, then drains them to memory in FIFO order.
- Serves cache read-misses either from buffered lines (forwarding) or by passing the request through to memory.
- Hides memory write latency from the cache stall path.

Parameters:
DEPTH, 4, number of buffered 256-bit lines (power of 2, >=2)
ADDR_W, 32, byte address width
LINE_W, 256, line width in bits
OFFSET_W, 5, line offset bits; the line tag compared is addr[ADDR_W-1:OFFSET_W]

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
cache_enable_i  in  1  cache request valid; held until cache_ack_o
cache_write_i  in  1  1=write-back line, 0=line fill read
cache_addr_i  in  ADDR_W  line address
cache_data_i  in  LINE_W  write-back data
cache_ack_o  out  1  one-cycle completion pulse
cache_data_o  out  LINE_W  read data; valid while cache_ack_o=1
mem_enable_o  out  1  memory request; held until mem_ack_i
mem_write_o  out  1  memory write
mem_addr_o  out  ADDR_W  memory line address
mem_data_o  out  LINE_W  memory write data
mem_ack_i  in  1  memory completion pulse
mem_data_i  in  LINE_W  memory read data; valid with mem_ack_i
buf_count_o  out  clog2(DEPTH+1)  occupied entries
buf_empty_o  out  1  buf_count_o==0 and no memory write in flight

Behaviour:
- Reset (async, rst_i=1) clears:
  - every entry valid bit, head, tail and count;
  - state to IDLE;
  - cache_ack_o, cache_data_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o to 0;
  - buf_count_o to 0; buf_empty_o is 1.
- Reset mid-operation: buffered data is discarded and mem_enable_o drops in the same cycle.
- States:
  - IDLE: no memory access outstanding.
  - DRAIN: head entry being written to memory.
  - RD_MEM: read miss outstanding at memory.
  - All memory outputs are registered and held stable while mem_enable_o=1.
- Request acceptance:
  - A request is evaluated only when cache_enable_i=1 and cache_ack_o=0. No re-acceptance occurs in the ack cycle.
  - Tag match is against valid entries on addr[ADDR_W-1:OFFSET_W]. At most one valid entry per tag exists at any time.
- Write, tag matches a non-in-flight entry: entry data is overwritten (coalesce). cache_ack_o=1 on the next cycle. Count is unchanged.
- Write, tag matches the head entry while that entry is in DRAIN: stall until that drain's mem_ack_i, then treat as a new push.
- Write, no match, count<DEPTH: push at tail. cache_ack_o=1 on the next cycle. Count +1.
- Write, count==DEPTH: stall, no ack. Acceptance occurs in the cycle after the head drain's mem_ack_i frees a slot.
- Read, tag match (including the in-flight head): cache_data_o=entry data and cache_ack_o=1 on the next cycle. No memory access.
- Read, no match:
  - From IDLE: go to RD_MEM with mem_enable_o=1, mem_write_o=0, mem_addr_o=cache_addr_i.
  - From DRAIN: wait for mem_ack_i, then go to RD_MEM.
  - On mem_ack_i in RD_MEM: latch mem_data_i into cache_data_o, pulse cache_ack_o on the next cycle, return to IDLE.
  - Miss latency = memory latency + 1.
- Drain start:
  - Condition: in IDLE with count>0 and no pending read miss (read miss has priority over drain).
  - In a cycle where an entry is written (push or coalesce), drain start is deferred one cycle.
  - DRAIN drives mem_enable_o=1, mem_write_o=1, and the head's addr/data.
  - On mem_ack_i: invalidate head, advance head (wrap modulo DEPTH), count -1, return to IDLE. Back-to-back drains are separated by one IDLE cycle.
- Count arithmetic:
  - Push and drain-complete in the same cycle leave count unchanged.
  - Head and tail pointers wrap at DEPTH.
  - Count never exceeds DEPTH and never underflows.
- mem_ack_i arriving while mem_enable_o=0 is ignored.

Test Plan:
1. Empty buffer, write addr 0x200 data A, memory latency 10:
   - ack 1 cycle later, count=1;
   - 2 cycles after acceptance, mem_enable_o=1, write=1, addr 0x200, data A;
   - after mem_ack_i, count=0 and buf_empty_o=1.
2. Entry 0x200=A pending with memory ack withheld, read 0x200 -> cache_ack_o pulse 1 cycle later, cache_data_o=A, no read issued to memory.
3. DEPTH=4, memory ack withheld, writes to 0x000, 0x020, 0x040, 0x060, 0x080:
   - first four acked, count=4;
   - fifth stalls with no ack until the 0x000 drain ack, then is acked the following cycle; count stays 4.
4. Writes 0x400=B then 0x400=C before drain -> count=1; memory receives exactly one write, 0x400 with C.
5. Read 0x040 (not buffered) issued during drain of 0x200:
   - no memory read until the drain ack;
   - then mem_write_o=0, addr 0x040;
   - cache_ack_o one cycle after mem_ack_i, with mem_data_i.
6. rst_i asserted mid-DRAIN with count=3 -> mem_enable_o=0 and count=0 immediately; first request after release behaves as scenario 1.

Source files
------------

// File: rtl/wb_line_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wb_line_buffer
// Purpose  : Write-back line buffer between the data cache memory port and
//            off-chip memory. Absorbs dirty-line write-backs with a short
//            acknowledge, drains them to memory in FIFO order, forwards
//            buffered lines to read misses and passes other misses through.
// Revision : 1.0 - initial release
// ============================================================================
module wb_line_buffer #(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 256,
  parameter int OFFSET_W = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  // cache side
  input  logic                         cache_enable_i,
  input  logic                         cache_write_i,
  input  logic [ADDR_W-1:0]            cache_addr_i,
  input  logic [LINE_W-1:0]            cache_data_i,
  output logic                         cache_ack_o,
  output logic [LINE_W-1:0]            cache_data_o,
  // memory side
  output logic                         mem_enable_o,
  output logic                         mem_write_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [LINE_W-1:0]            mem_data_o,
  input  logic                         mem_ack_i,
  input  logic [LINE_W-1:0]            mem_data_i,
  // status
  output logic [$clog2(DEPTH+1)-1:0]   buf_count_o,
  output logic                         buf_empty_o
);

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_CNT_W = $clog2(DEPTH+1);
  localparam int C_TAG_W = ADDR_W - OFFSET_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAIN  = 2'd1,
    S_RD_MEM = 2'd2
  } state_t;

  state_t               r_state;
  logic [DEPTH-1:0]     r_valid;
  logic [C_TAG_W-1:0]   r_tag  [DEPTH];
  logic [LINE_W-1:0]    r_data [DEPTH];
  logic [C_PTR_W-1:0]   r_head;
  logic [C_PTR_W-1:0]   r_tail;
  logic [C_CNT_W-1:0]   r_count;

  logic [C_TAG_W-1:0]   w_tag;
  logic                 w_req;
  logic                 w_hit;
  logic [C_PTR_W-1:0]   w_hit_idx;
  logic                 w_hit_inflight;
  logic                 w_full;
  logic                 w_mem_done;
  logic                 w_drain_done;
  logic                 w_rd_done;
  logic                 w_push;
  logic                 w_coalesce;
  logic                 w_rd_hit;
  logic                 w_rd_miss;
  logic                 w_rd_issue;
  logic                 w_drain_start;
  logic [C_CNT_W-1:0]   w_count_nxt;

  // A request is looked at only outside its own ack cycle; while a miss is
  // outstanding at memory the held request is already being serviced.
  assign w_tag   = cache_addr_i[ADDR_W-1:OFFSET_W];
  assign w_req   = cache_enable_i & ~cache_ack_o & (r_state != S_RD_MEM);
  assign w_full  = (r_count == C_CNT_W'(DEPTH));

  // Tag lookup across valid entries (at most one entry can match a tag)
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_idx = C_PTR_W'(i);
      end
    end
  end

  // The head entry is frozen while its write to memory is in progress.
  assign w_hit_inflight = w_hit & (r_state == S_DRAIN) & (w_hit_idx == r_head);

  // Memory completions only count while a request is actually outstanding.
  assign w_mem_done   = mem_ack_i & mem_enable_o;
  assign w_drain_done = w_mem_done & (r_state == S_DRAIN);
  assign w_rd_done    = w_mem_done & (r_state == S_RD_MEM);

  // Request classification. A write hitting the in-flight head, a write to a
  // full buffer and a read miss during a drain all simply stall.
  assign w_coalesce = w_req &  cache_write_i &  w_hit & ~w_hit_inflight;
  assign w_push     = w_req &  cache_write_i & ~w_hit & ~w_full;
  assign w_rd_hit   = w_req & ~cache_write_i &  w_hit;
  assign w_rd_miss  = w_req & ~cache_write_i & ~w_hit;
  assign w_rd_issue = w_rd_miss & (r_state == S_IDLE);

  // Read misses win over draining; a drain never starts in a cycle that
  // writes an entry so the head snapshot cannot race a coalesce.
  assign w_drain_start = (r_state == S_IDLE) & (r_count != '0) &
                         ~w_rd_miss & ~w_push & ~w_coalesce;

  // Occupancy update; a push and a drain completion cancel out
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_drain_done) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_drain_done) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Control FSM, pointers, valid bits and all registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      cache_ack_o  <= 1'b0;
      cache_data_o <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      cache_ack_o <= 1'b0;

      if (w_rd_hit) begin
        cache_ack_o  <= 1'b1;
        cache_data_o <= r_data[w_hit_idx];
      end

      if (w_push || w_coalesce) begin
        cache_ack_o <= 1'b1;
      end

      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_rd_issue) begin
            r_state      <= S_RD_MEM;
            mem_enable_o <= 1'b1;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= cache_addr_i;
          end else if (w_drain_start) begin
            r_state      <= S_DRAIN;
            mem_enable_o <= 1'b1;
            mem_write_o  <= 1'b1;
            mem_addr_o   <= {r_tag[r_head], {OFFSET_W{1'b0}}};
            mem_data_o   <= r_data[r_head];
          end
        end
        S_DRAIN: begin
          if (w_drain_done) begin
            r_state         <= S_IDLE;
            mem_enable_o    <= 1'b0;
            mem_write_o     <= 1'b0;
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + 1'b1;
          end
        end
        S_RD_MEM: begin
          if (w_rd_done) begin
            r_state      <= S_IDLE;
            mem_enable_o <= 1'b0;
            cache_ack_o  <= 1'b1;
            cache_data_o <= mem_data_i;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          mem_enable_o <= 1'b0;
          mem_write_o  <= 1'b0;
        end
      endcase

      r_count <= w_count_nxt;
    end
  end

  // Line storage: tag and data written on push, data only on coalesce
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_tag[r_tail]  <= w_tag;
      r_data[r_tail] <= cache_data_i;
    end
    if (w_coalesce) begin
      r_data[w_hit_idx] <= cache_data_i;
    end
  end

  assign buf_count_o = r_count;
  assign buf_empty_o = (r_count == '0) && (r_state != S_DRAIN);

endmodule
`default_nettype wire

// File: tb/tb_wb_line_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wb_line_buffer
// Purpose  : Directed self-checking bench for wb_line_buffer. Memory
//            acknowledges are driven by hand so every latency is known.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_line_buffer;

  localparam int DEPTH    = 4;
  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;
  localparam int CNT_W    = $clog2(DEPTH+1);

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                cache_enable_i;
  logic                cache_write_i;
  logic [ADDR_W-1:0]   cache_addr_i;
  logic [LINE_W-1:0]   cache_data_i;
  logic                cache_ack_o;
  logic [LINE_W-1:0]   cache_data_o;
  logic                mem_enable_o;
  logic                mem_write_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [LINE_W-1:0]   mem_data_o;
  logic                mem_ack_i;
  logic [LINE_W-1:0]   mem_data_i;
  logic [CNT_W-1:0]    buf_count_o;
  logic                buf_empty_o;

  int n_vec    = 0;
  int n_miscmp = 0;

  wb_line_buffer #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .LINE_W   (LINE_W),
    .OFFSET_W (OFFSET_W)
  ) u_dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cache_enable_i (cache_enable_i),
    .cache_write_i  (cache_write_i),
    .cache_addr_i   (cache_addr_i),
    .cache_data_i   (cache_data_i),
    .cache_ack_o    (cache_ack_o),
    .cache_data_o   (cache_data_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_ack_i      (mem_ack_i),
    .mem_data_i     (mem_data_i),
    .buf_count_o    (buf_count_o),
    .buf_empty_o    (buf_empty_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [LINE_W-1:0] pat(input logic [31:0] seed);
    return {8{seed}};
  endfunction

  task automatic check_vec(input string tag, input logic [LINE_W-1:0] got,
                           input logic [LINE_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock, then settle just past the edge for sampling and driving
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cache_start(input logic w, input logic [ADDR_W-1:0] a,
                             input logic [LINE_W-1:0] d);
    cache_enable_i = 1'b1;
    cache_write_i  = w;
    cache_addr_i   = a;
    cache_data_i   = d;
  endtask

  task automatic cache_stop();
    cache_enable_i = 1'b0;
    cache_write_i  = 1'b0;
  endtask

  // n = cycles until cache_ack_o seen, -1 if bound expires
  task automatic wait_ack(input int max, output int n);
    bit seen;
    seen = 1'b0;
    n    = -1;
    for (int k = 1; k <= max; k++) begin
      if (!seen) begin
        tick();
        if (cache_ack_o) begin
          seen = 1'b1;
          n    = k;
        end
      end
    end
  endtask

  // n = cycles until mem_enable_o seen (0 if already high), -1 on timeout
  task automatic wait_mem(input int max, output int n);
    bit seen;
    seen = mem_enable_o;
    n    = seen ? 0 : -1;
    for (int k = 1; k <= max; k++) begin
      if (!seen) begin
        tick();
        if (mem_enable_o) begin
          seen = 1'b1;
          n    = k;
        end
      end
    end
  endtask

  // full cache request expected to be acked one cycle after presentation
  task automatic cache_req(input string tag, input logic w,
                           input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
    int n;
    cache_start(w, a, d);
    wait_ack(6, n);
    check_vec(tag, LINE_W'(n), LINE_W'(1));
    cache_stop();
    tick();
  endtask

  task automatic mem_pulse(input logic [LINE_W-1:0] d);
    mem_data_i = d;
    mem_ack_i  = 1'b1;
    tick();
    mem_ack_i  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int extra;

    rst_i          = 1'b1;
    cache_enable_i = 1'b0;
    cache_write_i  = 1'b0;
    cache_addr_i   = '0;
    cache_data_i   = '0;
    mem_ack_i      = 1'b0;
    mem_data_i     = '0;
    tick();
    tick();
    rst_i = 1'b0;
    tick();

    // reset state
    check_vec("rst_ack",   LINE_W'(cache_ack_o),  LINE_W'(0));
    check_vec("rst_cdata", cache_data_o,          '0);
    check_vec("rst_men",   LINE_W'(mem_enable_o), LINE_W'(0));
    check_vec("rst_mwr",   LINE_W'(mem_write_o),  LINE_W'(0));
    check_vec("rst_maddr", LINE_W'(mem_addr_o),   LINE_W'(0));
    check_vec("rst_mdata", mem_data_o,            '0);
    check_vec("rst_cnt",   LINE_W'(buf_count_o),  LINE_W'(0));
    check_vec("rst_empty", LINE_W'(buf_empty_o),  LINE_W'(1));

    // 1: single write-back, drain with memory latency 10
    cache_start(1'b1, 32'h200, pat(32'hA0A0_0001));
    wait_ack(6, n);
    check_vec("s1_ack_lat", LINE_W'(n), LINE_W'(1));
    check_vec("s1_cnt1", LINE_W'(buf_count_o), LINE_W'(1));
    cache_stop();
    tick();
    check_vec("s1_men",   LINE_W'(mem_enable_o), LINE_W'(1));
    check_vec("s1_mwr",   LINE_W'(mem_write_o),  LINE_W'(1));
    check_vec("s1_maddr", LINE_W'(mem_addr_o),   LINE_W'(32'h200));
    check_vec("s1_mdata", mem_data_o,            pat(32'hA0A0_0001));
    check_vec("s1_busy",  LINE_W'(buf_empty_o),  LINE_W'(0));
    repeat (9) tick();
    check_vec("s1_hold",  LINE_W'(mem_enable_o), LINE_W'(1));
    mem_pulse('0);
    check_vec("s1_cnt0",  LINE_W'(buf_count_o),  LINE_W'(0));
    check_vec("s1_empty", LINE_W'(buf_empty_o),  LINE_W'(1));
    check_vec("s1_mdrop", LINE_W'(mem_enable_o), LINE_W'(0));

    // 2: read hit on the in-flight head, no memory read
    cache_req("s2_wr_ack", 1'b1, 32'h200, pat(32'hA0A0_0002));
    wait_mem(4, n);
    check_vec("s2_drain_go", LINE_W'(mem_enable_o), LINE_W'(1));
    cache_start(1'b0, 32'h200, '0);
    wait_ack(6, n);
    check_vec("s2_rd_lat",  LINE_W'(n), LINE_W'(1));
    check_vec("s2_rd_data", cache_data_o, pat(32'hA0A0_0002));
    cache_stop();
    tick();
    check_vec("s2_no_mrd",  LINE_W'(mem_write_o), LINE_W'(1));
    check_vec("s2_maddr",   LINE_W'(mem_addr_o),  LINE_W'(32'h200));
    mem_pulse('0);
    check_vec("s2_cnt0",    LINE_W'(buf_count_o), LINE_W'(0));

    // 3: fill to DEPTH with drain ack withheld, fifth write stalls
    for (int i = 0; i < 4; i++) begin
      cache_req("s3_fill_ack", 1'b1, ADDR_W'(i * 32'h20), pat(32'hC000_0000 + i));
    end
    check_vec("s3_cnt4",   LINE_W'(buf_count_o), LINE_W'(4));
    check_vec("s3_maddr0", LINE_W'(mem_addr_o),  LINE_W'(32'h000));
    cache_start(1'b1, 32'h080, pat(32'hC000_0004));
    wait_ack(6, n);
    check_vec("s3_full_stall", LINE_W'(n), LINE_W'(-1));
    check_vec("s3_cnt_full",   LINE_W'(buf_count_o), LINE_W'(4));
    mem_pulse('0);
    check_vec("s3_no_early_ack", LINE_W'(cache_ack_o), LINE_W'(0));
    wait_ack(4, n);
    check_vec("s3_late_ack",  LINE_W'(n), LINE_W'(1));
    check_vec("s3_cnt_after", LINE_W'(buf_count_o), LINE_W'(4));
    cache_stop();
    tick();
    for (int j = 1; j <= 4; j++) begin
      wait_mem(6, n);
      check_vec("s3_d_en",    LINE_W'(mem_enable_o), LINE_W'(1));
      check_vec("s3_d_wr",    LINE_W'(mem_write_o),  LINE_W'(1));
      check_vec("s3_d_addr",  LINE_W'(mem_addr_o),   LINE_W'(j * 32'h20));
      check_vec("s3_d_data",  mem_data_o,            pat(32'hC000_0000 + j));
      mem_pulse('0);
      check_vec("s3_d_gap",   LINE_W'(mem_enable_o), LINE_W'(0));
    end
    check_vec("s3_cnt0", LINE_W'(buf_count_o), LINE_W'(0));

    // 4: coalesce two writes to 0x400 behind a held drain of 0x300
    cache_req("s4_wr300", 1'b1, 32'h300, pat(32'h3333_0000));
    cache_req("s4_wrB",   1'b1, 32'h400, pat(32'hBBBB_0000));
    cache_req("s4_wrC",   1'b1, 32'h400, pat(32'hCCCC_0000));
    check_vec("s4_cnt2",  LINE_W'(buf_count_o), LINE_W'(2));
    check_vec("s4_addr300", LINE_W'(mem_addr_o), LINE_W'(32'h300));
    mem_pulse('0);
    wait_mem(6, n);
    check_vec("s4_addr400", LINE_W'(mem_addr_o), LINE_W'(32'h400));
    check_vec("s4_dataC",   mem_data_o,          pat(32'hCCCC_0000));
    mem_pulse('0);
    extra = 0;
    repeat (6) begin
      tick();
      if (mem_enable_o) extra++;
    end
    check_vec("s4_one_write", LINE_W'(extra), LINE_W'(0));
    check_vec("s4_cnt0", LINE_W'(buf_count_o), LINE_W'(0));

    // 5: read miss arriving during a drain waits, then passes through
    cache_req("s5_wr_ack", 1'b1, 32'h200, pat(32'hA0A0_0005));
    wait_mem(4, n);
    check_vec("s5_drain_addr", LINE_W'(mem_addr_o), LINE_W'(32'h200));
    cache_start(1'b0, 32'h040, '0);
    wait_ack(4, n);
    check_vec("s5_rd_stall", LINE_W'(n), LINE_W'(-1));
    check_vec("s5_no_mrd",   LINE_W'(mem_write_o), LINE_W'(1));
    mem_pulse('0);
    check_vec("s5_no_ack", LINE_W'(cache_ack_o), LINE_W'(0));
    wait_mem(4, n);
    check_vec("s5_rd_en",   LINE_W'(mem_enable_o), LINE_W'(1));
    check_vec("s5_rd_wr",   LINE_W'(mem_write_o),  LINE_W'(0));
    check_vec("s5_rd_addr", LINE_W'(mem_addr_o),   LINE_W'(32'h040));
    repeat (3) tick();
    check_vec("s5_wait_ack", LINE_W'(cache_ack_o), LINE_W'(0));
    mem_pulse(pat(32'hDEAD_0040));
    check_vec("s5_ack",  LINE_W'(cache_ack_o), LINE_W'(1));
    check_vec("s5_data", cache_data_o,         pat(32'hDEAD_0040));
    cache_stop();
    tick();
    check_vec("s5_ack_pulse", LINE_W'(cache_ack_o),  LINE_W'(0));
    check_vec("s5_mem_idle",  LINE_W'(mem_enable_o), LINE_W'(0));
    check_vec("s5_cnt0",      LINE_W'(buf_count_o),  LINE_W'(0));

    // 6: reset in the middle of a drain with three lines buffered
    cache_req("s6_wr0", 1'b1, 32'h000, pat(32'h6666_0000));
    cache_req("s6_wr1", 1'b1, 32'h020, pat(32'h6666_0001));
    cache_req("s6_wr2", 1'b1, 32'h040, pat(32'h6666_0002));
    check_vec("s6_cnt3",   LINE_W'(buf_count_o),  LINE_W'(3));
    check_vec("s6_drain",  LINE_W'(mem_enable_o), LINE_W'(1));
    rst_i = 1'b1;
    #1;
    check_vec("s6_rst_men",   LINE_W'(mem_enable_o), LINE_W'(0));
    check_vec("s6_rst_cnt",   LINE_W'(buf_count_o),  LINE_W'(0));
    check_vec("s6_rst_empty", LINE_W'(buf_empty_o),  LINE_W'(1));
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    cache_start(1'b1, 32'h200, pat(32'hF00D_0006));
    wait_ack(6, n);
    check_vec("s6_ack_lat", LINE_W'(n), LINE_W'(1));
    check_vec("s6_cnt1",    LINE_W'(buf_count_o), LINE_W'(1));
    cache_stop();
    tick();
    check_vec("s6_men",   LINE_W'(mem_enable_o), LINE_W'(1));
    check_vec("s6_maddr", LINE_W'(mem_addr_o),   LINE_W'(32'h200));
    check_vec("s6_mdata", mem_data_o,            pat(32'hF00D_0006));
    repeat (9) tick();
    mem_pulse('0);
    check_vec("s6_cnt0",  LINE_W'(buf_count_o), LINE_W'(0));
    check_vec("s6_empty", LINE_W'(buf_empty_o), LINE_W'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
`default_nettype wire
